reg_file_sb: RTL

Parametrised successor to the core register file: 2**A x W storage with NRD independent read ports and two write ports. Port A is the single-cycle ALU/immediate write; port B is the late load-return write. A per-register scoreboard tracks loads in flight, so decode can stall on read-after-load hazards. Optional r0-reads-zero mode and write-to-read bypass are selected by parameter. Sits between decode/operand fetch and the ALU/data-memory writeback paths.

---
 rtl/reg_file_sb.sv | 127 ++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2**A x W register file with NRD combinational read ports,
// an ALU write port (A), a load-return write port (B) and a per-register
// load-pending scoreboard used by decode to stall on read-after-load hazards.
module reg_file_sb #(
    parameter int W      = 8,
    parameter int A      = 4,
    parameter int NRD    = 3,
    parameter int R0ZERO = 1,
    parameter int BYPASS = 1
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic [NRD*A-1:0] RdAddr,
    input  logic [NRD-1:0]   RdReq,
    output logic [NRD*W-1:0] RdData,
    output logic [NRD-1:0]   RdBusy,
    output logic             Stall,
    input  logic             WrEnA,
    input  logic [A-1:0]     WrAddrA,
    input  logic [W-1:0]     WrDataA,
    input  logic             WrEnB,
    input  logic [A-1:0]     WrAddrB,
    input  logic [W-1:0]     WrDataB,
    input  logic             PendSet,
    input  logic [A-1:0]     PendAddr,
    output logic [A:0]       PendCount,
    output logic             WawErr
);

    localparam int DEPTH = 1 << A;

    logic [W-1:0]     regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_next;
    logic [A:0]       pend_cnt;
    logic             waw_err;

    logic             wr_a_ok;
    logic             wr_b_ok;
    logic             set_ok;
    logic             rise;
    logic             fall;
    logic             waw_hit;
    logic [A-1:0]     rd_addr;

    // Qualify writes/sets (r0 protection, port A wins collisions) and derive
    // the scoreboard next state; a new load (set) overrides a same-cycle return.
    always_comb begin
        wr_a_ok   = WrEnA && !((R0ZERO != 0) && (WrAddrA == '0));
        wr_b_ok   = WrEnB && !((R0ZERO != 0) && (WrAddrB == '0))
                    && !(WrEnA && (WrAddrA == WrAddrB));
        set_ok    = PendSet && !((R0ZERO != 0) && (PendAddr == '0));
        rise      = set_ok && !pend[PendAddr];
        fall      = WrEnB && pend[WrAddrB] && !(set_ok && (PendAddr == WrAddrB));
        waw_hit   = WrEnA && pend[WrAddrA] && !(WrEnB && (WrAddrB == WrAddrA))
                    && !((R0ZERO != 0) && (WrAddrA == '0));
        pend_next = pend;
        if (WrEnB) begin
            pend_next[WrAddrB] = 1'b0;
        end
        if (set_ok) begin
            pend_next[PendAddr] = 1'b1;
        end
    end

    // Register storage: reset clears everything and overrides same-cycle writes.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (wr_a_ok) begin
                regs[WrAddrA] <= WrDataA;
            end
            if (wr_b_ok) begin
                regs[WrAddrB] <= WrDataB;
            end
        end
    end

    // Scoreboard bits, incremental pending counter and sticky WAW error flag.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            pend     <= '0;
            pend_cnt <= '0;
            waw_err  <= 1'b0;
        end else begin
            pend     <= pend_next;
            pend_cnt <= pend_cnt + (A+1)'(rise) - (A+1)'(fall);
            waw_err  <= waw_err | waw_hit;
        end
    end

    // Combinational read ports: r0 rule, then port A bypass, then port B
    // bypass, then stored value. A returning load hides its pending bit.
    always_comb begin
        RdData  = '0;
        RdBusy  = '0;
        rd_addr = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_addr = RdAddr[i*A +: A];
            if ((R0ZERO != 0) && (rd_addr == '0)) begin
                RdData[i*W +: W] = '0;
                RdBusy[i]        = 1'b0;
            end else begin
                if ((BYPASS != 0) && WrEnA && (WrAddrA == rd_addr)) begin
                    RdData[i*W +: W] = WrDataA;
                end else if ((BYPASS != 0) && WrEnB && (WrAddrB == rd_addr)) begin
                    RdData[i*W +: W] = WrDataB;
                end else begin
                    RdData[i*W +: W] = regs[rd_addr];
                end
                if ((BYPASS != 0) && WrEnB && (WrAddrB == rd_addr)) begin
                    RdBusy[i] = 1'b0;
                end else begin
                    RdBusy[i] = pend[rd_addr];
                end
            end
        end
    end

    assign Stall     = |(RdReq & RdBusy);
    assign PendCount = pend_cnt;
    assign WawErr    = waw_err;

endmodule
